// File: rtl/csi2_packet_sequencer_if.sv
// Bundle of the header, payload beat and pixel-side signals that run between
// the CSI-2 byte receiver, the packet sequencer and the downstream pixel
// unpacker.
//   master : the receiver / testbench side. It drives the header fields,
//            the payload beats and err_clear, and observes every result.
//   slave  : the packet sequencer. It consumes headers and beats, and drives
//            packet_done, the pixel beats, the frame/line state and the
//            sticky error flags.
interface csi2_packet_sequencer_if;
  logic        header_valid;
  logic [1:0]  virtual_channel;
  logic [5:0]  data_type;
  logic [15:0] word_count;
  logic        image_data_enable;
  logic [31:0] image_data;
  logic        err_clear;

  logic        packet_done;
  logic        pixel_enable;
  logic [31:0] pixel_data;
  logic [3:0]  byte_mask;
  logic        frame_start;
  logic        frame_end;
  logic        line_end;
  logic        frame_active;
  logic [15:0] frame_number;
  logic [15:0] line_number;
  logic        err_sequence;
  logic        err_timeout;
  logic        err_protocol;

  modport master (
    output header_valid, virtual_channel, data_type, word_count,
           image_data_enable, image_data, err_clear,
    input  packet_done, pixel_enable, pixel_data, byte_mask, frame_start,
           frame_end, line_end, frame_active, frame_number, line_number,
           err_sequence, err_timeout, err_protocol
  );

  modport slave (
    input  header_valid, virtual_channel, data_type, word_count,
           image_data_enable, image_data, err_clear,
    output packet_done, pixel_enable, pixel_data, byte_mask, frame_start,
           frame_end, line_end, frame_active, frame_number, line_number,
           err_sequence, err_timeout, err_protocol
  );
endinterface

// File: rtl/csi2_packet_sequencer.sv
// CSI-2 packet-level sequencer. It counts long-packet payload against the
// word count, pulses packet_done so the receiver returns to sync hunting,
// filters traffic by virtual channel, and tracks the frame and line state.
// It forwards qualified 4-byte pixel beats with byte masks, and raises
// sticky sequence, timeout and protocol error flags.
// Ports:
//   clock : receiver byte clock
//   reset : synchronous, active-high
//   bus   : csi2_packet_sequencer_if.slave. It carries the header and beat
//           inputs plus err_clear, and the packet_done, pixel, frame/line
//           and error outputs.
//
// state   | meaning
// IDLE    | waiting for a packet header
// PAYLOAD | long packet, counting payload beats, idle timer running
// DONE    | packet consumed, packet_done asserted this cycle
module csi2_packet_sequencer #(
  parameter logic [1:0]  VC_FILTER      = 2'd0,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                   clock,
  input  logic                   reset,
  csi2_packet_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DONE    = 2'd2
  } state_t;

  // The idle timer counts down from here; it expires on the idle cycle that
  // finds the counter at zero, which is the TIMEOUT_CYCLES-th idle cycle.
  localparam logic [15:0] IDLE_LOAD = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [14:0] beats_left_q;
  logic [15:0] idle_cnt_q;
  logic [3:0]  last_mask_q;
  logic        qualify_q;
  logic        line_pkt_q;

  logic        packet_done_q;
  logic        pixel_enable_q;
  logic [31:0] pixel_data_q;
  logic [3:0]  byte_mask_q;
  logic        frame_start_q;
  logic        frame_end_q;
  logic        line_end_q;
  logic        frame_active_q;
  logic [15:0] frame_number_q;
  logic [15:0] line_number_q;
  logic        err_sequence_q;
  logic        err_timeout_q;
  logic        err_protocol_q;

  logic        is_short;
  logic        vc_match;
  logic        hdr_accept;
  logic        beat;
  logic        last_beat;
  logic        timeout;
  logic        proto_err;
  logic        seq_err;
  logic [14:0] wc_beats;
  logic [3:0]  last_mask_d;

  assign is_short   = bus.data_type < 6'h10;
  assign vc_match   = bus.virtual_channel == VC_FILTER;
  assign hdr_accept = (state_q == IDLE) && bus.header_valid;
  assign beat       = (state_q == PAYLOAD) && bus.image_data_enable;
  assign last_beat  = beat && (beats_left_q == 15'd1);
  assign timeout    = (state_q == PAYLOAD) && !bus.image_data_enable &&
                      (idle_cnt_q == 16'd0);
  // A header outside IDLE and a beat outside PAYLOAD are both dropped. This
  // also covers a beat that arrives in the same IDLE cycle as a header.
  assign proto_err  = (bus.header_valid && (state_q != IDLE)) ||
                      (bus.image_data_enable && (state_q != PAYLOAD));
  assign wc_beats   = 15'((32'(bus.word_count) + 32'd3) >> 2);

  always_comb begin
    last_mask_d = 4'b1111;
    case (bus.word_count[1:0])
      2'd1:    last_mask_d = 4'b0001;
      2'd2:    last_mask_d = 4'b0011;
      2'd3:    last_mask_d = 4'b0111;
      default: last_mask_d = 4'b1111;
    endcase
  end

  always_comb begin
    seq_err = 1'b0;
    if (hdr_accept && vc_match) begin
      if (!is_short)
        seq_err = !frame_active_q;
      else if (bus.data_type == 6'h00)
        seq_err = frame_active_q;
      else if (bus.data_type == 6'h01)
        seq_err = !frame_active_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (bus.header_valid)
          state_d = (is_short || (bus.word_count == 16'd0)) ? DONE : PAYLOAD;
      PAYLOAD:
        if (last_beat || timeout)
          state_d = DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      beats_left_q   <= '0;
      idle_cnt_q     <= '0;
      last_mask_q    <= '0;
      qualify_q      <= 1'b0;
      line_pkt_q     <= 1'b0;
      packet_done_q  <= 1'b0;
      pixel_enable_q <= 1'b0;
      pixel_data_q   <= '0;
      byte_mask_q    <= '0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      line_end_q     <= 1'b0;
      frame_active_q <= 1'b0;
      frame_number_q <= '0;
      line_number_q  <= '0;
      err_sequence_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_protocol_q <= 1'b0;
    end else begin
      // DONE lasts exactly one cycle, so packet_done mirrors entry into it.
      packet_done_q  <= (state_d == DONE);
      pixel_enable_q <= 1'b0;
      byte_mask_q    <= 4'b0000;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      line_end_q     <= 1'b0;

      if (hdr_accept) begin
        beats_left_q <= wc_beats;
        idle_cnt_q   <= IDLE_LOAD;
        last_mask_q  <= last_mask_d;
        // Qualification is frozen at the header, because the frame state
        // cannot change while the payload is in flight.
        qualify_q    <= vc_match && frame_active_q;
        line_pkt_q   <= vc_match && frame_active_q && (bus.data_type >= 6'h18);
        if (is_short && vc_match) begin
          if (bus.data_type == 6'h00) begin
            frame_start_q  <= 1'b1;
            frame_active_q <= 1'b1;
            frame_number_q <= bus.word_count;
            line_number_q  <= 16'd0;
          end else if ((bus.data_type == 6'h01) && frame_active_q) begin
            frame_end_q    <= 1'b1;
            frame_active_q <= 1'b0;
          end
        end
      end

      if (beat) begin
        beats_left_q <= beats_left_q - 15'd1;
        idle_cnt_q   <= IDLE_LOAD;
        if (qualify_q) begin
          pixel_enable_q <= 1'b1;
          pixel_data_q   <= bus.image_data;
          byte_mask_q    <= last_beat ? last_mask_q : 4'b1111;
          if (last_beat && line_pkt_q) begin
            line_end_q    <= 1'b1;
            line_number_q <= line_number_q + 16'd1;
          end
        end
      end else if (state_q == PAYLOAD) begin
        idle_cnt_q <= idle_cnt_q - 16'd1;
      end

      // A new error wins over a concurrent clear.
      err_sequence_q <= seq_err   | (err_sequence_q & ~bus.err_clear);
      err_timeout_q  <= timeout   | (err_timeout_q  & ~bus.err_clear);
      err_protocol_q <= proto_err | (err_protocol_q & ~bus.err_clear);
    end
  end

  assign bus.packet_done  = packet_done_q;
  assign bus.pixel_enable = pixel_enable_q;
  assign bus.pixel_data   = pixel_data_q;
  assign bus.byte_mask    = byte_mask_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.frame_end    = frame_end_q;
  assign bus.line_end     = line_end_q;
  assign bus.frame_active = frame_active_q;
  assign bus.frame_number = frame_number_q;
  assign bus.line_number  = line_number_q;
  assign bus.err_sequence = err_sequence_q;
  assign bus.err_timeout  = err_timeout_q;
  assign bus.err_protocol = err_protocol_q;

endmodule
